// File: rtl/opl3_timer_bank.sv
// OPL3-style programmable timer bank: a shared prescaler feeds a cascade of tick strobes.
// Each timer is an up-counter that reloads on overflow and raises a sticky, maskable IRQ flag.
module opl3_timer_bank #(
  parameter int NUM_TIMERS       = 2,
  parameter int TIMER_WIDTH      = 8,
  parameter int BASE_TICK_CYCLES = 4000,
  parameter int TICK_RATIO       = 4
) (
  input  logic                                i_clk,
  input  logic                                i_reset,
  input  logic [NUM_TIMERS*TIMER_WIDTH-1:0]   i_timer_preload,
  input  logic [NUM_TIMERS-1:0]               i_timer_start,
  input  logic [NUM_TIMERS-1:0]               i_timer_mask,
  input  logic                                i_irq_rst,
  output logic [NUM_TIMERS-1:0]               o_status_flag,
  output logic                                o_irq,
  output logic [NUM_TIMERS-1:0]               o_overflow_pulse,
  output logic [NUM_TIMERS-1:0]               o_tick
);

  localparam int PW = $clog2(BASE_TICK_CYCLES);
  localparam int RW = (TICK_RATIO > 1) ? $clog2(TICK_RATIO) : 1;
  localparam logic [PW-1:0] PRESCALE_LAST = PW'(BASE_TICK_CYCLES - 1);
  localparam logic [RW-1:0] RATIO_LAST    = RW'(TICK_RATIO - 1);

  logic [PW-1:0]         r_prescaler;
  logic [NUM_TIMERS-1:0] w_tick_int;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_prescaler <= '0;
    end else if (r_prescaler == PRESCALE_LAST) begin
      r_prescaler <= '0;
    end else begin
      r_prescaler <= r_prescaler + 1'b1;
    end
  end

  assign w_tick_int[0] = (r_prescaler == PRESCALE_LAST);

  // Every slower tick is a subset of the faster one, so all strobes align with a base tick.
  genvar gi;
  generate
    for (gi = 1; gi < NUM_TIMERS; gi++) begin : g_cascade
      logic [RW-1:0] r_ratio;

      always_ff @(posedge i_clk) begin
        if (i_reset) begin
          r_ratio <= '0;
        end else if (w_tick_int[gi-1]) begin
          r_ratio <= (r_ratio == RATIO_LAST) ? '0 : r_ratio + 1'b1;
        end
      end

      assign w_tick_int[gi] = w_tick_int[gi-1] && (r_ratio == RATIO_LAST);
    end
  endgenerate

  generate
    for (gi = 0; gi < NUM_TIMERS; gi++) begin : g_timer
      logic                   r_start_prev;
      logic [TIMER_WIDTH-1:0] r_count;
      logic                   r_ovf;
      logic                   r_flag;
      logic                   r_tick;
      logic [TIMER_WIDTH-1:0] w_preload;
      logic                   w_start_rise;
      logic                   w_run_tick;
      logic                   w_overflow;

      assign w_preload    = i_timer_preload[gi*TIMER_WIDTH +: TIMER_WIDTH];
      assign w_start_rise = i_timer_start[gi] & ~r_start_prev;
      assign w_run_tick   = i_timer_start[gi] & r_start_prev & w_tick_int[gi];
      assign w_overflow   = w_run_tick & (&r_count);

      always_ff @(posedge i_clk) begin
        if (i_reset) begin
          r_start_prev <= 1'b0;
          r_count      <= '0;
          r_ovf        <= 1'b0;
          r_flag       <= 1'b0;
          r_tick       <= 1'b0;
        end else begin
          r_start_prev <= i_timer_start[gi];
          r_ovf        <= w_overflow;
          r_tick       <= w_tick_int[gi];
          // Preload is sampled only here, so changes while running wait for the next reload.
          if (w_start_rise || w_overflow) begin
            r_count <= w_preload;
          end else if (w_run_tick) begin
            r_count <= r_count + 1'b1;
          end
          // A set from an unmasked overflow beats a coincident clear.
          if (w_overflow && !i_timer_mask[gi]) begin
            r_flag <= 1'b1;
          end else if (i_irq_rst) begin
            r_flag <= 1'b0;
          end
        end
      end

      assign o_overflow_pulse[gi] = r_ovf;
      assign o_status_flag[gi]    = r_flag;
      assign o_tick[gi]           = r_tick;
    end
  endgenerate

  assign o_irq = |o_status_flag;

endmodule

// File: tb/tb_opl3_timer_bank.sv
// Scoreboard bench for opl3_timer_bank: a per-edge reference model predicts outputs,
// a separate monitor pops and compares them half a cycle after each edge.
module tb_opl3_timer_bank;

  localparam int NT    = 2;
  localparam int TW    = 8;
  localparam int BASE  = 4;
  localparam int RATIO = 4;

  logic          clk;
  logic          reset;
  logic [NT*TW-1:0] timer_preload;
  logic [NT-1:0] timer_start;
  logic [NT-1:0] timer_mask;
  logic          irq_rst;
  logic [NT-1:0] status_flag;
  logic          irq;
  logic [NT-1:0] overflow_pulse;
  logic [NT-1:0] tick;

  opl3_timer_bank #(
    .NUM_TIMERS(NT), .TIMER_WIDTH(TW), .BASE_TICK_CYCLES(BASE), .TICK_RATIO(RATIO)
  ) dut (
    .i_clk(clk), .i_reset(reset), .i_timer_preload(timer_preload),
    .i_timer_start(timer_start), .i_timer_mask(timer_mask), .i_irq_rst(irq_rst),
    .o_status_flag(status_flag), .o_irq(irq), .o_overflow_pulse(overflow_pulse), .o_tick(tick)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct packed {
    logic [NT-1:0] ovf;
    logic [NT-1:0] flag;
    logic          irq;
    logic [NT-1:0] tick;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  // Reference model: timer i ticks on every (BASE*RATIO**i)-th edge since reset release.
  int unsigned m_cyc;
  logic [TW-1:0] m_cnt [NT];
  logic [NT-1:0] m_prev;
  logic [NT-1:0] m_flag;

  function automatic bit tick_at(int i, int unsigned c);
    int unsigned p;
    p = BASE * (RATIO ** i);
    return (c % p) == p - 1;
  endfunction

  function automatic bit ovf_next(int i);
    return !reset && timer_start[i] && m_prev[i] && tick_at(i, m_cyc) && (m_cnt[i] == 8'hFF);
  endfunction

  function automatic void model_step();
    exp_t e;
    logic [TW-1:0] pre;
    e = '0;
    if (reset) begin
      m_cyc  = 0;
      m_prev = '0;
      m_flag = '0;
      for (int i = 0; i < NT; i++) m_cnt[i] = '0;
    end else begin
      for (int i = 0; i < NT; i++) begin
        e.tick[i] = tick_at(i, m_cyc);
        pre = timer_preload[i*TW +: TW];
        if (timer_start[i] && !m_prev[i]) begin
          m_cnt[i] = pre;
        end else if (timer_start[i] && e.tick[i]) begin
          if (m_cnt[i] == 8'hFF) begin
            e.ovf[i] = 1'b1;
            m_cnt[i] = pre;
          end else begin
            m_cnt[i] = m_cnt[i] + 8'd1;
          end
        end
        m_prev[i] = timer_start[i];
        if (e.ovf[i] && !timer_mask[i]) m_flag[i] = 1'b1;
        else if (irq_rst)               m_flag[i] = 1'b0;
      end
      m_cyc++;
      e.flag = m_flag;
      e.irq  = |m_flag;
    end
    exp_q.push_back(e);
  endfunction

  function automatic void chk(string name, logic [NT-1:0] act, logic [NT-1:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s at %0t: got %b expected %b", name, $time, act, exp);
  endfunction

  // Monitor: one expected record per clock edge, compared on the following falling edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("overflow_pulse", overflow_pulse, e.ovf);
        chk("status_flag", status_flag, e.flag);
        chk("irq", {1'b0, irq}, {1'b0, e.irq});
        chk("tick", tick, e.tick);
        if (overflow_pulse != '0)
          $display("t=%0t overflow_pulse=%b status_flag=%b irq=%b", $time, overflow_pulse, status_flag, irq);
      end
    end
  end

  task automatic run(int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      model_step();
      #1;
    end
  endtask

  task automatic pulse_irq_rst();
    irq_rst = 1'b1;
    run(1);
    irq_rst = 1'b0;
  endtask

  initial begin
    int j;
    reset = 1'b1; timer_preload = '0; timer_start = '0; timer_mask = '0; irq_rst = 1'b0;
    run(3);
    reset = 1'b0;
    run(5);

    // T0 at 0xFE: overflow every two base ticks.
    timer_preload[7:0] = 8'hFE;
    timer_start[0] = 1'b1;
    run(40);

    // T1 at 0xFF: overflow on every T1 tick.
    timer_preload[15:8] = 8'hFF;
    timer_start[1] = 1'b1;
    run(64);

    // Masked T0 keeps pulsing but cannot set its flag.
    timer_mask = 2'b11;
    pulse_irq_rst();
    run(40);
    timer_mask = 2'b00;

    // irq_rst coincident with an overflow: the overflow wins.
    run(20);
    for (int k = 0; k < 100 && !ovf_next(0); k++) run(1);
    pulse_irq_rst();
    run(3);
    pulse_irq_rst();
    run(3);

    // Hold T0 at 0xFD for 40 clocks, then restart from preload.
    timer_start[1] = 1'b0;
    timer_start[0] = 1'b0;
    run(2);
    timer_preload[7:0] = 8'hF0;
    timer_start[0] = 1'b1;
    for (int k = 0; k < 200 && m_cnt[0] != 8'hFD; k++) run(1);
    timer_start[0] = 1'b0;
    run(40);
    timer_start[0] = 1'b1;
    run(60);

    // Preload change mid-run takes effect only at the next reload.
    timer_preload[7:0] = 8'hFE;
    timer_start[0] = 1'b0;
    run(1);
    timer_start[0] = 1'b1;
    run(6);
    timer_preload[7:0] = 8'hFC;
    run(50);

    // Reset mid-count with start held high.
    timer_start = 2'b11;
    reset = 1'b1;
    run(2);
    reset = 1'b0;
    run(40);

    // Randomised traffic.
    for (int k = 0; k < 1500; k++) begin
      j = $urandom_range(0, NT-1);
      if ($urandom_range(0, 15) == 0) timer_start[j] = ~timer_start[j];
      j = $urandom_range(0, NT-1);
      if ($urandom_range(0, 31) == 0) timer_mask[j] = ~timer_mask[j];
      j = $urandom_range(0, NT-1);
      if ($urandom_range(0, 15) == 0) timer_preload[j*TW +: TW] = 8'($urandom_range(240, 255));
      irq_rst = ($urandom_range(0, 11) == 0);
      reset   = ($urandom_range(0, 499) == 0);
      run(1);
    end
    irq_rst = 1'b0;
    reset   = 1'b0;
    run(4);

    @(negedge clk);
    #1;
    n_checks++;
    if (exp_q.size() == 0) n_pass++;
    else $display("FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size());

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
